eth_clk_rst_seq: RTL and testbench

Clock/reset sequencer for the Ethernet clocking block. It runs on the free-running board reference clock and drives the MMCM reset. It waits for a stable lock, then performs a timed PHY hardware reset and releases the Ethernet-domain reset request. On lock loss it re-sequences automatically, with bounded retries, and reports status for CSR readout.

---
 rtl/eth_pkg.sv | 51 +++++
 rtl/eth_clk_rst_seq_if.sv | 25 ++
 rtl/eth_sync_2ff.sv | 24 ++
 rtl/eth_clk_rst_seq.sv | 143 ++++++++++++++
 tb/tb_eth_clk_rst_seq.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/eth_pkg.sv
// Shared types and default sequencing constants for the Ethernet clocking block.
package eth_pkg;

  typedef enum logic [2:0] {
    RST_MMCM  = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    PHY_RST   = 3'd3,
    PHY_WAIT  = 3'd4,
    RUN       = 3'd5,
    FAIL      = 3'd6
  } eth_seq_st_t;

  localparam int unsigned DEF_RST_CYCLES      = 16;
  localparam int unsigned DEF_LOCK_TIMEOUT    = 100000;
  localparam int unsigned DEF_STABLE_CYCLES   = 1024;
  localparam int unsigned DEF_PHY_RST_CYCLES  = 1000000;
  localparam int unsigned DEF_PHY_WAIT_CYCLES = 500000;
  localparam int unsigned DEF_MAX_RETRIES     = 3;
  localparam int unsigned DEF_CNT_W           = 32;

  typedef struct packed {
    logic mmcm_rst;
    logic phy_rst_n;
    logic eth_rst_n;
    logic ready;
    logic fail;
  } eth_seq_out_t;

  // Output decode for a sequencer state; every pin is a pure function of state.
  function automatic eth_seq_out_t seq_outputs(input eth_seq_st_t st);
    eth_seq_out_t o;
    o = '{mmcm_rst: 1'b0, phy_rst_n: 1'b0, eth_rst_n: 1'b0, ready: 1'b0, fail: 1'b0};
    case (st)
      RST_MMCM: o.mmcm_rst = 1'b1;
      PHY_WAIT: o.phy_rst_n = 1'b1;
      RUN: begin
        o.phy_rst_n = 1'b1;
        o.eth_rst_n = 1'b1;
        o.ready     = 1'b1;
      end
      FAIL: begin
        o.mmcm_rst = 1'b1;
        o.fail     = 1'b1;
      end
      default: ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/eth_clk_rst_seq_if.sv
// Control/status bundle between the clock/reset sequencer and its environment.
interface eth_clk_rst_seq_if;
  logic       clk_locked;
  logic       soft_restart;
  logic       mmcm_rst;
  logic       phy_rst_n;
  logic       eth_rst_n;
  logic       ready;
  logic       fail;
  logic [1:0] retry_cnt;
  logic [7:0] lock_loss_cnt;
  logic [2:0] state_o;

  modport master (
    input  clk_locked, soft_restart,
    output mmcm_rst, phy_rst_n, eth_rst_n, ready, fail,
           retry_cnt, lock_loss_cnt, state_o
  );

  modport slave (
    output clk_locked, soft_restart,
    input  mmcm_rst, phy_rst_n, eth_rst_n, ready, fail,
           retry_cnt, lock_loss_cnt, state_o
  );
endinterface

// File: rtl/eth_sync_2ff.sv
// Two-flop synchronizer for level signals crossing into the clk domain.
module eth_sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // NOTE: non-blocking assignments keep meta->q a true two-stage pipeline.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/eth_clk_rst_seq.sv
// Clock/reset sequencer: MMCM reset, lock qualification, timed PHY reset and
// Ethernet-domain reset release, with bounded lock-timeout retries.
module eth_clk_rst_seq
  import eth_pkg::*;
#(
  parameter int unsigned RST_CYCLES      = DEF_RST_CYCLES,
  parameter int unsigned LOCK_TIMEOUT    = DEF_LOCK_TIMEOUT,
  parameter int unsigned STABLE_CYCLES   = DEF_STABLE_CYCLES,
  parameter int unsigned PHY_RST_CYCLES  = DEF_PHY_RST_CYCLES,
  parameter int unsigned PHY_WAIT_CYCLES = DEF_PHY_WAIT_CYCLES,
  parameter int unsigned MAX_RETRIES     = DEF_MAX_RETRIES,
  parameter int unsigned CNT_W           = DEF_CNT_W
) (
  input  logic              clk_in,
  input  logic              rst_in,
  eth_clk_rst_seq_if.master bus
);

  localparam logic [CNT_W-1:0] LD_RST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_LOCK   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LD_STABLE = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_PHYRST = CNT_W'(PHY_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_PHYWT  = CNT_W'(PHY_WAIT_CYCLES - 1);
  localparam logic [1:0]       MAX_R     = 2'(MAX_RETRIES);

  eth_seq_st_t      state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [1:0]       retry_q, retry_nx;
  logic [7:0]       llc_q, llc_nx;
  eth_seq_out_t     out_q;
  logic             lock_s;
  logic             cnt_zero;

  eth_sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk   (clk_in),
    .rst_n (rst_in),
    .d     (bus.clk_locked),
    .q     (lock_s)
  );

  assign cnt_zero = (cnt == '0);

  // NOTE: every variable gets a default first, so no path can infer a latch.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt_zero ? cnt : cnt - CNT_W'(1);
    retry_nx = retry_q;
    llc_nx   = llc_q;

    if (bus.soft_restart) begin
      state_nx = RST_MMCM;
      cnt_nx   = LD_RST;
      retry_nx = '0;
    end else begin
      // Lock-related exits are tested before counter expiry so they win ties.
      case (state)
        RST_MMCM: if (cnt_zero) begin
          state_nx = WAIT_LOCK;
          cnt_nx   = LD_LOCK;
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            state_nx = STABLE;
            cnt_nx   = LD_STABLE;
          end else if (cnt_zero) begin
            if (retry_q < MAX_R) begin
              state_nx = RST_MMCM;
              cnt_nx   = LD_RST;
              retry_nx = retry_q + 2'd1;
            end else begin
              state_nx = FAIL;
            end
          end
        end
        STABLE: begin
          if (!lock_s) begin
            state_nx = WAIT_LOCK;
            cnt_nx   = LD_LOCK;
          end else if (cnt_zero) begin
            state_nx = PHY_RST;
            cnt_nx   = LD_PHYRST;
          end
        end
        PHY_RST: begin
          if (!lock_s) begin
            state_nx = RST_MMCM;
            cnt_nx   = LD_RST;
          end else if (cnt_zero) begin
            state_nx = PHY_WAIT;
            cnt_nx   = LD_PHYWT;
          end
        end
        PHY_WAIT: begin
          if (!lock_s) begin
            state_nx = RST_MMCM;
            cnt_nx   = LD_RST;
          end else if (cnt_zero) begin
            state_nx = RUN;
          end
        end
        RUN: if (!lock_s) begin
          state_nx = RST_MMCM;
          cnt_nx   = LD_RST;
          retry_nx = '0;
          if (llc_q != 8'hFF) llc_nx = llc_q + 8'd1;
        end
        FAIL: ;
        default: begin
          state_nx = RST_MMCM;
          cnt_nx   = LD_RST;
        end
      endcase
    end
  end

  // Outputs are registered from the next-state decode, so they always match
  // the state register and never glitch.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state   <= RST_MMCM;
      cnt     <= LD_RST;
      retry_q <= '0;
      llc_q   <= '0;
      out_q   <= seq_outputs(RST_MMCM);
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      retry_q <= retry_nx;
      llc_q   <= llc_nx;
      out_q   <= seq_outputs(state_nx);
    end
  end

  assign bus.mmcm_rst      = out_q.mmcm_rst;
  assign bus.phy_rst_n     = out_q.phy_rst_n;
  assign bus.eth_rst_n     = out_q.eth_rst_n;
  assign bus.ready         = out_q.ready;
  assign bus.fail          = out_q.fail;
  assign bus.retry_cnt     = retry_q;
  assign bus.lock_loss_cnt = llc_q;
  assign bus.state_o       = state;

endmodule

// File: tb/tb_eth_clk_rst_seq.sv
// Directed bench for eth_clk_rst_seq: table-driven bring-up plus hand-written
// lock-loss, retry, glitch, priority, reset and saturation sequences.
module tb_eth_clk_rst_seq;
  import eth_pkg::*;

  localparam int S_MMCM = 0;
  localparam int S_PHY  = 1;
  localparam int S_ETH  = 2;
  localparam int S_RDY  = 3;
  localparam int NV     = 13;

  typedef struct {
    string       name;
    logic        rst_n;
    logic        lock;
    int          ticks;
    logic [17:0] exp;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;
  int   n;
  bit   phy_hi_seen;
  bit   ready_seen;
  vec_t vecs[NV];

  eth_clk_rst_seq_if bus ();

  eth_clk_rst_seq #(
    .RST_CYCLES      (4),
    .LOCK_TIMEOUT    (20),
    .STABLE_CYCLES   (8),
    .PHY_RST_CYCLES  (10),
    .PHY_WAIT_CYCLES (6),
    .MAX_RETRIES     (2),
    .CNT_W           (32)
  ) dut (
    .clk_in (clk),
    .rst_in (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (bus.phy_rst_n === 1'b1) phy_hi_seen = 1'b1;
    if (bus.ready === 1'b1) ready_seen = 1'b1;
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      S_MMCM:  return bus.mmcm_rst;
      S_PHY:   return bus.phy_rst_n;
      S_ETH:   return bus.eth_rst_n;
      default: return bus.ready;
    endcase
  endfunction

  function automatic logic [17:0] obs();
    return {bus.mmcm_rst, bus.phy_rst_n, bus.eth_rst_n, bus.ready, bus.fail,
            bus.state_o, bus.retry_cnt, bus.lock_loss_cnt};
  endfunction

  function automatic logic [17:0] mk(input logic m, input logic p, input logic e,
                                     input logic r, input logic f, input logic [2:0] s,
                                     input logic [1:0] rc, input logic [7:0] l);
    return {m, p, e, r, f, s, rc, l};
  endfunction

  function automatic vec_t vec(input string name, input logic rs, input logic lk,
                               input int t, input logic [17:0] e);
    vec_t v;
    v.name = name; v.rst_n = rs; v.lock = lk; v.ticks = t; v.exp = e;
    return v;
  endfunction

  task automatic wait_sig(input string name, input int sel, input logic val,
                          input int budget, output int cnt);
    cnt = 0;
    while (sig(sel) !== val && cnt < budget) begin step(); cnt++; end
    check(name, 32'(sig(sel)), 32'(val));
  endtask

  task automatic wait_state(input string name, input logic [2:0] s, input int budget,
                            output int cnt);
    cnt = 0;
    while (bus.state_o !== s && cnt < budget) begin step(); cnt++; end
    check(name, 32'(bus.state_o), 32'(s));
  endtask

  task automatic run_len(input int sel, input logic val, input int budget, output int cnt);
    cnt = 0;
    while (sig(sel) === val && cnt < budget) begin step(); cnt++; end
  endtask

  task automatic run_state(input logic [2:0] s, input int budget, output int cnt);
    cnt = 0;
    while (bus.state_o === s && cnt < budget) begin step(); cnt++; end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    bus.clk_locked   = 1'b0;
    bus.soft_restart = 1'b0;
    phy_hi_seen = 1'b0;
    ready_seen  = 1'b0;

    // Nominal bring-up timeline; lock rises 5 cycles after mmcm_rst falls.
    vecs[0]  = vec("reset state",        0, 0, 2,  mk(1,0,0,0,0,RST_MMCM, 0,0));
    vecs[1]  = vec("mmcm_rst cycle 4",   1, 0, 3,  mk(1,0,0,0,0,RST_MMCM, 0,0));
    vecs[2]  = vec("mmcm_rst released",  1, 0, 1,  mk(0,0,0,0,0,WAIT_LOCK,0,0));
    vecs[3]  = vec("waiting for lock",   1, 0, 5,  mk(0,0,0,0,0,WAIT_LOCK,0,0));
    vecs[4]  = vec("lock in sync",       1, 1, 2,  mk(0,0,0,0,0,WAIT_LOCK,0,0));
    vecs[5]  = vec("enter stable",       1, 1, 1,  mk(0,0,0,0,0,STABLE,   0,0));
    vecs[6]  = vec("stable last cycle",  1, 1, 7,  mk(0,0,0,0,0,STABLE,   0,0));
    vecs[7]  = vec("enter phy_rst",      1, 1, 1,  mk(0,0,0,0,0,PHY_RST,  0,0));
    vecs[8]  = vec("phy_rst last cycle", 1, 1, 9,  mk(0,0,0,0,0,PHY_RST,  0,0));
    vecs[9]  = vec("phy_rst_n rises",    1, 1, 1,  mk(0,1,0,0,0,PHY_WAIT, 0,0));
    vecs[10] = vec("phy_wait last cyc",  1, 1, 5,  mk(0,1,0,0,0,PHY_WAIT, 0,0));
    vecs[11] = vec("eth_rst_n rises",    1, 1, 1,  mk(0,1,1,1,0,RUN,      0,0));
    vecs[12] = vec("run holds",          1, 1, 10, mk(0,1,1,1,0,RUN,      0,0));

    for (int i = 0; i < NV; i++) begin
      rst_n          = vecs[i].rst_n;
      bus.clk_locked = vecs[i].lock;
      repeat (vecs[i].ticks) step();
      check(vecs[i].name, 32'(obs()), 32'(vecs[i].exp));
    end

    // Lock loss in RUN: one-cycle drop on clk_locked.
    bus.clk_locked = 1'b0;
    step();
    bus.clk_locked = 1'b1;
    wait_sig("eth_rst_n low after lock drop", S_ETH, 1'b0, 8, n);
    check("lock drop to eth_rst_n latency", 32'(n + 1), 32'd3);
    check("ready low after lock drop", 32'(bus.ready), 32'd0);
    run_len(S_MMCM, 1'b1, 10, n);
    check("mmcm_rst pulse after lock loss", 32'(n), 32'd4);
    check("lock_loss_cnt after one drop", 32'(bus.lock_loss_cnt), 32'd1);
    wait_sig("ready after re-sequence", S_RDY, 1'b1, 60, n);
    check("retry_cnt after re-sequence", 32'(bus.retry_cnt), 32'd0);

    // Retries exhausted: lock held low from a soft restart.
    bus.clk_locked   = 1'b0;
    bus.soft_restart = 1'b1;
    step();
    bus.soft_restart = 1'b0;
    check("soft_restart from RUN", 32'(bus.state_o), 32'(RST_MMCM));
    run_len(S_MMCM, 1'b1, 10, n);
    check("first mmcm_rst pulse", 32'(n), 32'd4);
    run_len(S_MMCM, 1'b0, 30, n);
    check("first lock timeout", 32'(n), 32'd20);
    check("retry_cnt after first timeout", 32'(bus.retry_cnt), 32'd1);
    run_len(S_MMCM, 1'b1, 10, n);
    check("second mmcm_rst pulse", 32'(n), 32'd4);
    run_len(S_MMCM, 1'b0, 30, n);
    check("second lock timeout", 32'(n), 32'd20);
    check("retry_cnt after second timeout", 32'(bus.retry_cnt), 32'd2);
    run_len(S_MMCM, 1'b1, 10, n);
    check("third mmcm_rst pulse", 32'(n), 32'd4);
    run_len(S_MMCM, 1'b0, 30, n);
    check("third lock timeout", 32'(n), 32'd20);
    check("fail/mmcm_rst/state after retries",
          32'({bus.fail, bus.mmcm_rst, bus.state_o}), 32'({1'b1, 1'b1, FAIL}));
    repeat (5) step();
    check("fail is terminal", 32'({bus.fail, bus.state_o}), 32'({1'b1, FAIL}));
    bus.soft_restart = 1'b1;
    step();
    bus.soft_restart = 1'b0;
    check("soft_restart leaves fail",
          32'({bus.state_o, bus.retry_cnt, bus.fail}), 32'({RST_MMCM, 2'd0, 1'b0}));
    check("lock_loss_cnt kept by soft_restart", 32'(bus.lock_loss_cnt), 32'd1);

    // Glitchy lock: drop for one cycle while in the fifth STABLE cycle.
    bus.clk_locked = 1'b1;
    phy_hi_seen    = 1'b0;
    wait_state("reach stable", STABLE, 12, n);
    repeat (4) step();
    bus.clk_locked = 1'b0;
    step();
    bus.clk_locked = 1'b1;
    wait_state("glitch returns to wait_lock", WAIT_LOCK, 6, n);
    wait_state("re-enter stable", STABLE, 6, n);
    run_state(STABLE, 20, n);
    check("stable restarts full length", 32'(n), 32'd8);
    check("stable exits to phy_rst", 32'(bus.state_o), 32'(PHY_RST));
    check("phy_rst_n low through glitch", 32'(phy_hi_seen), 32'd0);

    // soft_restart in the same cycle PHY_WAIT expires.
    ready_seen = 1'b0;
    wait_state("reach phy_wait", PHY_WAIT, 20, n);
    repeat (5) step();
    bus.soft_restart = 1'b1;
    step();
    bus.soft_restart = 1'b0;
    check("soft_restart beats phy_wait expiry", 32'(bus.state_o), 32'(RST_MMCM));
    repeat (3) step();
    check("ready never asserted", 32'(ready_seen), 32'd0);

    // Synchronous reset in the middle of PHY_RST.
    wait_state("reach phy_rst", PHY_RST, 40, n);
    repeat (3) step();
    rst_n = 1'b0;
    step();
    check("reset during phy_rst", 32'(obs()), 32'(mk(1,0,0,0,0,RST_MMCM,0,0)));
    rst_n = 1'b1;

    // Saturation of lock_loss_cnt over 260 drops in RUN.
    wait_sig("ready before saturation run", S_RDY, 1'b1, 60, n);
    for (int i = 0; i < 260; i++) begin
      bus.clk_locked = 1'b0;
      step();
      bus.clk_locked = 1'b1;
      wait_sig("ready falls on drop", S_RDY, 1'b0, 10, n);
      wait_sig("ready returns", S_RDY, 1'b1, 60, n);
      if (i == 0) check("lock_loss_cnt first drop after reset", 32'(bus.lock_loss_cnt), 32'd1);
    end
    check("lock_loss_cnt saturates", 32'(bus.lock_loss_cnt), 32'd255);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
